// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: tracks E/M/W destinations and Tnew, emits forwarding selects and the D-stage stall.
// Latency: stall and F_* are combinational from registered stage state and the D inputs; state updates each clk edge.
// Backpressure: stall freezes PC and F/D and inserts a bubble into E, while M and W keep advancing.
//
// Ports: clk/reset (synchronous, active-high); A1_D/A2_D/A3_D, Tuse_rs_D/Tuse_rt_D, kind_D,
//        md_start_D and md_use_D describe the D instruction; stall, F_RS_D, F_RT_D, F_RS_E,
//        F_RT_E, F_RT_M drive the pipeline; md_busy reports a running multiply/divide.
module hazard_ctrl #(
   parameter int MULT_CYC = 5,
   parameter int DIV_CYC  = 10
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [4:0] A1_D,
   input  logic [4:0] A2_D,
   input  logic [4:0] A3_D,
   input  logic [1:0] Tuse_rs_D,
   input  logic [1:0] Tuse_rt_D,
   input  logic [1:0] kind_D,
   input  logic [1:0] md_start_D,
   input  logic       md_use_D,
   output logic       stall,
   output logic [2:0] F_RS_D,
   output logic [2:0] F_RT_D,
   output logic [2:0] F_RS_E,
   output logic [2:0] F_RT_E,
   output logic [2:0] F_RT_M,
   output logic       md_busy
);

   localparam int CW = $clog2(DIV_CYC + 1);
   localparam logic [CW-1:0] MULT_LD = CW'(MULT_CYC);
   localparam logic [CW-1:0] DIV_LD  = CW'(DIV_CYC);

   localparam logic [1:0] K_NONE = 2'b00;
   localparam logic [1:0] K_PC8  = 2'b01;
   localparam logic [1:0] K_ALU  = 2'b10;
   localparam logic [1:0] K_DM   = 2'b11;

   // stage state
   logic [4:0]    a1_e_q, a2_e_q, a3_e_q, a2_m_q, a3_m_q, a3_w_q;
   logic [1:0]    kind_e_q, tnew_e_q, mdop_e_q, kind_m_q, tnew_m_q, kind_w_q;
   logic [CW-1:0] cnt_q;

   logic [4:0]    a1_e_d, a2_e_d, a3_e_d, a2_m_d, a3_m_d, a3_w_d;
   logic [1:0]    kind_e_d, tnew_e_d, mdop_e_d, kind_m_d, tnew_m_d, kind_w_d;
   logic [CW-1:0] cnt_d;

   // A source register must wait if a producer still needs more cycles than the consumer can tolerate.
   function automatic logic reg_hazard(input logic [4:0] a, input logic [1:0] tuse);
      reg_hazard = (a != 5'd0) &&
                   (((a == a3_e_q) && (tnew_e_q > tuse)) ||
                    ((a == a3_m_q) && (tnew_m_q > tuse)));
   endfunction

   // D select: nearest matching stage wins even when it cannot forward yet (stall covers it).
   function automatic logic [2:0] fwd_d(input logic [4:0] a);
      fwd_d = 3'd0;
      if (a == 5'd0) begin
         fwd_d = 3'd0;
      end else if (a == a3_e_q) begin
         fwd_d = (kind_e_q == K_PC8) ? 3'd1 : 3'd0;
      end else if (a == a3_m_q) begin
         if (tnew_m_q == 2'd0)
            fwd_d = (kind_m_q == K_PC8) ? 3'd2 : (kind_m_q == K_ALU) ? 3'd3 : 3'd0;
      end else if (a == a3_w_q) begin
         // a load in W is covered by register-file write-through, hence 000
         fwd_d = (kind_w_q == K_PC8) ? 3'd4 : (kind_w_q == K_ALU) ? 3'd5 : 3'd0;
      end
   endfunction

   function automatic logic [2:0] fwd_e(input logic [4:0] a);
      fwd_e = 3'd0;
      if (a == 5'd0) begin
         fwd_e = 3'd0;
      end else if (a == a3_m_q) begin
         if (tnew_m_q == 2'd0)
            fwd_e = (kind_m_q == K_PC8) ? 3'd1 : (kind_m_q == K_ALU) ? 3'd2 : 3'd0;
      end else if (a == a3_w_q) begin
         fwd_e = (kind_w_q == K_PC8) ? 3'd3 : (kind_w_q == K_ALU) ? 3'd4 : 3'd5;
      end
   endfunction

   always_comb begin
      stall   = reg_hazard(A1_D, Tuse_rs_D) || reg_hazard(A2_D, Tuse_rt_D) ||
                (md_use_D && ((cnt_q != '0) || (mdop_e_q != 2'b00)));
      md_busy = (cnt_q != '0);
      F_RS_D  = fwd_d(A1_D);
      F_RT_D  = fwd_d(A2_D);
      F_RS_E  = fwd_e(a1_e_q);
      F_RT_E  = fwd_e(a2_e_q);
      F_RT_M  = 3'd0;
      if ((a2_m_q != 5'd0) && (a2_m_q == a3_w_q))
         F_RT_M = (kind_w_q == K_PC8) ? 3'd1 : (kind_w_q == K_ALU) ? 3'd2 : 3'd3;
   end

   always_comb begin
      a1_e_d   = A1_D;
      a2_e_d   = A2_D;
      a3_e_d   = (kind_D == K_NONE) ? 5'd0 : A3_D;
      kind_e_d = kind_D;
      mdop_e_d = md_start_D;
      case (kind_D)
         K_ALU:   tnew_e_d = 2'd1;
         K_DM:    tnew_e_d = 2'd2;
         default: tnew_e_d = 2'd0;
      endcase
      if (stall) begin
         a1_e_d   = 5'd0;
         a2_e_d   = 5'd0;
         a3_e_d   = 5'd0;
         kind_e_d = K_NONE;
         tnew_e_d = 2'd0;
         mdop_e_d = 2'b00;
      end

      a2_m_d   = a2_e_q;
      a3_m_d   = a3_e_q;
      kind_m_d = kind_e_q;
      tnew_m_d = (tnew_e_q == 2'd0) ? 2'd0 : tnew_e_q - 2'd1;

      a3_w_d   = a3_m_q;
      kind_w_d = kind_m_q;

      // a new operation entering E restarts the count even if one is still running
      if (mdop_e_q == 2'b01)
         cnt_d = MULT_LD;
      else if (mdop_e_q != 2'b00)
         cnt_d = DIV_LD;
      else if (cnt_q != '0)
         cnt_d = cnt_q - CW'(1);
      else
         cnt_d = cnt_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         a1_e_q   <= 5'd0;
         a2_e_q   <= 5'd0;
         a3_e_q   <= 5'd0;
         kind_e_q <= 2'd0;
         tnew_e_q <= 2'd0;
         mdop_e_q <= 2'd0;
         a2_m_q   <= 5'd0;
         a3_m_q   <= 5'd0;
         kind_m_q <= 2'd0;
         tnew_m_q <= 2'd0;
         a3_w_q   <= 5'd0;
         kind_w_q <= 2'd0;
         cnt_q    <= '0;
      end else begin
         a1_e_q   <= a1_e_d;
         a2_e_q   <= a2_e_d;
         a3_e_q   <= a3_e_d;
         kind_e_q <= kind_e_d;
         tnew_e_q <= tnew_e_d;
         mdop_e_q <= mdop_e_d;
         a2_m_q   <= a2_m_d;
         a3_m_q   <= a3_m_d;
         kind_m_q <= kind_m_d;
         tnew_m_q <= tnew_m_d;
         a3_w_q   <= a3_w_d;
         kind_w_q <= kind_w_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule
